vram_read_arbiter: RTL and testbench
====================================

# vram_read_arbiter

Shares the single synchronous read port of the GPU video memory (13-bit address, 8-bit data, one-cycle registered read) between the video scanout fetcher and the CPU bus bridge. Scanout has fixed priority, and a bounded starvation guard guarantees the CPU a slot. The block accepts at most one request per cycle, drives the memory address, and routes the returned byte to the requester that was granted. It sits between the two requesters and the memory block inside the GPU.

## Interface
Parameters:
- ADDR_WIDTH, 13, memory address width
- DATA_WIDTH, 8, memory data width
- STARVE_LIMIT, 8, consecutive scanout grants tolerated while the CPU waits; legal range 1..255
- STALL_CNT_WIDTH, 16, width of the CPU stall counter

Ports:
- clk  in  1  single clock for the block and the memory
- reset_n  in  1  reset, asynchronous and active-low
- vid_req_valid  in  1  scanout read request
- vid_req_addr  in  ADDR_WIDTH  scanout address
- vid_req_ready  out  1  scanout request accepted this cycle
- vid_rsp_valid  out  1  scanout data valid
- vid_rsp_data  out  DATA_WIDTH  scanout read data
- cpu_req_valid  in  1  CPU read request
- cpu_req_addr  in  ADDR_WIDTH  CPU address
- cpu_req_ready  out  1  CPU request accepted this cycle
- cpu_rsp_valid  out  1  CPU data valid
- cpu_rsp_data  out  DATA_WIDTH  CPU read data
- mem_addr  out  ADDR_WIDTH  to memory read address
- mem_data  in  DATA_WIDTH  from memory read data
- cpu_stall_cycles  out  STALL_CNT_WIDTH  saturating count of cycles with cpu_req_valid=1 and cpu_req_ready=0

## Operation
- A request is accepted on a clock edge when valid=1 and ready=1 in the preceding cycle. Requesters hold valid and addr stable until they see ready.
- Grant is combinational each cycle, at most one side:
  - force_cpu = cpu_req_valid && starve_cnt == STARVE_LIMIT.
  - vid granted if vid_req_valid && !force_cpu.
  - Otherwise cpu granted if cpu_req_valid.
- vid_req_ready and cpu_req_ready equal the respective grant. They are never both 1.
- mem_addr selects the granted address. With no grant it holds last_addr, the register of the last granted address, so the address does not toggle.
- Response tag register: captures NONE/VID/CPU at every edge.
  - Tag VID: vid_rsp_valid=1.
  - Tag CPU: cpu_rsp_valid=1.
  - Both rsp_data outputs pass mem_data through and are meaningful only while the matching rsp_valid=1.
- No response backpressure. The requester must consume the response in its valid cycle.
- starve_cnt, 8-bit, updated at each edge:
  - Cleared on a CPU grant, or when cpu_req_valid=0.
  - Incremented on a vid grant while cpu_req_valid=1.
  - Saturates at STARVE_LIMIT.
- cpu_stall_cycles increments per stall cycle and saturates at all-ones; it does not wrap.

## Timing
- Request accepted at edge k: memory samples mem_addr at edge k, and rsp_valid is high for exactly the cycle after edge k.
- Latency is 1 cycle.
- Throughput is one request per cycle. Back-to-back grants to alternating sides return in the same order.
- Simultaneous valid on both sides: vid wins unless force_cpu.
- Worst-case CPU wait is STARVE_LIMIT cycles of continuous scanout traffic plus 1.
- Reset (asynchronous assert, any time):
  - Tag becomes NONE, so both rsp_valid are 0 and any in-flight response is dropped.
  - starve_cnt=0, last_addr=0, cpu_stall_cycles=0.
  - ready outputs follow the grant logic, which is combinational and unaffected.
- Deassertion is synchronous to clk at the system level. The first accepted request is at the first edge after deassert.

## Structure
- Package vram_arb_pkg holds:
  - grant tag enum: GNT_NONE, GNT_VID, GNT_CPU
  - default width constants: ADDR_WIDTH, DATA_WIDTH
- One sub-module is natural: vram_arb_starve_ctr, the saturating starvation counter with its force_cpu output.
- Grant mux, tag register, address hold and stall counter stay in the top.

## Test plan
- Single CPU read: memory preloaded with 0x5A at 0x0123; cpu_req addr 0x0123 for one cycle with vid idle -> cpu_req_ready=1 that cycle, cpu_rsp_valid=1 with data 0x5A in the next cycle, and vid_rsp_valid stays 0.
- Contention with default STARVE_LIMIT=8: vid_req_valid held high with incrementing addresses, CPU requests at cycle 0 -> vid granted for cycles 0-7, cpu granted at cycle 8, vid resumes at cycle 9, and cpu_stall_cycles=8.
- Alternating grants: vid 0x0000, cpu 0x1000, vid 0x0001 on consecutive cycles -> responses appear in order on the correct ports, each exactly one cycle after its grant.
- Idle hold: after a grant to 0x0ABC, both requesters idle for 5 cycles -> mem_addr stays 0x0ABC and both rsp_valid stay 0.
- Reset mid-operation: assert reset_n=0 between a CPU grant and its response cycle -> cpu_rsp_valid does not pulse, and after release starve_cnt=0 and cpu_stall_cycles=0.
- Saturation: force cpu_stall_cycles near 0xFFFF via a long stall with a small STALL_CNT_WIDTH=4 -> the counter stops at 0xF.

Source files
------------

// File: rtl/vram_arb_pkg.sv
// Shared types and default widths for the VRAM read-port arbiter.
// No logic, so no latency.
// No flow control lives here.
package vram_arb_pkg;

    localparam int ADDR_WIDTH = 13;
    localparam int DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_VID  = 2'd1,
        GNT_CPU  = 2'd2
    } gnt_tag_e;

endpackage

// File: rtl/vram_arb_starve_ctr.sv
// Counts scanout grants that go by while the CPU waits, and raises force_cpu at the limit.
// force_cpu is combinational from the registered count; the count updates one edge later.
// Holds at STARVE_LIMIT until the CPU is granted or drops its request.
module vram_arb_starve_ctr #(
    parameter int STARVE_LIMIT = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic cpu_req_valid_i,
    input  logic vid_gnt_i,
    input  logic cpu_gnt_i,
    output logic force_cpu_o
);

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    logic [7:0] starve_q;
    logic [7:0] starve_d;

    always_comb begin
        starve_d = starve_q;
        if (!cpu_req_valid_i || cpu_gnt_i) begin
            starve_d = 8'd0;
        end else if (vid_gnt_i && starve_q != LIMIT) begin
            starve_d = starve_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            starve_q <= 8'd0;
        end else begin
            starve_q <= starve_d;
        end
    end

    assign force_cpu_o = cpu_req_valid_i && (starve_q == LIMIT);

endmodule

// File: rtl/vram_read_arbiter.sv
// Shares the VRAM synchronous read port between scanout (priority) and the CPU bridge.
// Grant and address are combinational; the response is valid exactly one cycle after acceptance.
// Requesters wait on ready; responses have no backpressure and must be consumed when valid.
module vram_read_arbiter
    import vram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH      = vram_arb_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH      = vram_arb_pkg::DATA_WIDTH,
    parameter int STARVE_LIMIT    = 8,
    parameter int STALL_CNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       vid_req_valid,
    input  logic [ADDR_WIDTH-1:0]      vid_req_addr,
    output logic                       vid_req_ready,
    output logic                       vid_rsp_valid,
    output logic [DATA_WIDTH-1:0]      vid_rsp_data,
    input  logic                       cpu_req_valid,
    input  logic [ADDR_WIDTH-1:0]      cpu_req_addr,
    output logic                       cpu_req_ready,
    output logic                       cpu_rsp_valid,
    output logic [DATA_WIDTH-1:0]      cpu_rsp_data,
    output logic [ADDR_WIDTH-1:0]      mem_addr,
    input  logic [DATA_WIDTH-1:0]      mem_data,
    output logic [STALL_CNT_WIDTH-1:0] cpu_stall_cycles
);

    logic                       force_cpu;
    logic                       vid_gnt;
    logic                       cpu_gnt;
    gnt_tag_e                   tag_q;
    gnt_tag_e                   tag_d;
    logic [ADDR_WIDTH-1:0]      last_addr_q;
    logic [ADDR_WIDTH-1:0]      last_addr_d;
    logic [STALL_CNT_WIDTH-1:0] stall_q;
    logic [STALL_CNT_WIDTH-1:0] stall_d;

    vram_arb_starve_ctr #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk             (clk),
        .reset_n         (reset_n),
        .cpu_req_valid_i (cpu_req_valid),
        .vid_gnt_i       (vid_gnt),
        .cpu_gnt_i       (cpu_gnt),
        .force_cpu_o     (force_cpu)
    );

    always_comb begin
        vid_gnt     = vid_req_valid && !force_cpu;
        cpu_gnt     = cpu_req_valid && !vid_gnt;
        tag_d       = GNT_NONE;
        last_addr_d = last_addr_q;
        if (vid_gnt) begin
            tag_d       = GNT_VID;
            last_addr_d = vid_req_addr;
        end else if (cpu_gnt) begin
            tag_d       = GNT_CPU;
            last_addr_d = cpu_req_addr;
        end
        stall_d = stall_q;
        if (cpu_req_valid && !cpu_gnt && stall_q != '1) begin
            stall_d = stall_q + STALL_CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tag_q       <= GNT_NONE;
            last_addr_q <= '0;
            stall_q     <= '0;
        end else begin
            tag_q       <= tag_d;
            last_addr_q <= last_addr_d;
            stall_q     <= stall_d;
        end
    end

    // Idle cycles present the previous address so the memory input does not toggle.
    assign mem_addr         = last_addr_d;
    assign vid_req_ready    = vid_gnt;
    assign cpu_req_ready    = cpu_gnt;
    assign vid_rsp_valid    = (tag_q == GNT_VID);
    assign cpu_rsp_valid    = (tag_q == GNT_CPU);
    assign vid_rsp_data     = mem_data;
    assign cpu_rsp_data     = mem_data;
    assign cpu_stall_cycles = stall_q;

endmodule

// File: tb/tb_vram_read_arbiter.sv
// Randomized and directed bench for vram_read_arbiter against a behavioural model,
// with a second instance at STALL_CNT_WIDTH=4 to exercise counter saturation.
module tb_vram_read_arbiter;

    localparam int AW    = 13;
    localparam int DW    = 8;
    localparam int LIMIT = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          vid_req_valid = 1'b0;
    logic [AW-1:0] vid_req_addr = '0;
    logic          cpu_req_valid = 1'b0;
    logic [AW-1:0] cpu_req_addr = '0;
    logic [DW-1:0] mem_data = '0;

    logic          vid_req_ready, vid_rsp_valid, cpu_req_ready, cpu_rsp_valid;
    logic [DW-1:0] vid_rsp_data, cpu_rsp_data;
    logic [AW-1:0] mem_addr;
    logic [15:0]   cpu_stall_cycles;

    logic          s_vid_req_ready, s_vid_rsp_valid, s_cpu_req_ready, s_cpu_rsp_valid;
    logic [DW-1:0] s_vid_rsp_data, s_cpu_rsp_data;
    logic [AW-1:0] s_mem_addr;
    logic [3:0]    s_stall;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    int n_cmp  = 0;
    int n_fail = 0;

    // model state
    int            m_wait;
    int            m_stall;
    int            m_stall4;
    int            m_rsp_side;
    logic [AW-1:0] m_rsp_addr;
    logic [AW-1:0] m_last;
    logic          g_vid, g_cpu;

    always #5 clk = ~clk;

    always @(posedge clk) mem_data <= mem[mem_addr];

    vram_read_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .vid_req_valid(vid_req_valid), .vid_req_addr(vid_req_addr), .vid_req_ready(vid_req_ready),
        .vid_rsp_valid(vid_rsp_valid), .vid_rsp_data(vid_rsp_data),
        .cpu_req_valid(cpu_req_valid), .cpu_req_addr(cpu_req_addr), .cpu_req_ready(cpu_req_ready),
        .cpu_rsp_valid(cpu_rsp_valid), .cpu_rsp_data(cpu_rsp_data),
        .mem_addr(mem_addr), .mem_data(mem_data), .cpu_stall_cycles(cpu_stall_cycles)
    );

    vram_read_arbiter #(.STALL_CNT_WIDTH(4)) dut_s (
        .clk(clk), .reset_n(reset_n),
        .vid_req_valid(vid_req_valid), .vid_req_addr(vid_req_addr), .vid_req_ready(s_vid_req_ready),
        .vid_rsp_valid(s_vid_rsp_valid), .vid_rsp_data(s_vid_rsp_data),
        .cpu_req_valid(cpu_req_valid), .cpu_req_addr(cpu_req_addr), .cpu_req_ready(s_cpu_req_ready),
        .cpu_rsp_valid(s_cpu_rsp_valid), .cpu_rsp_data(s_cpu_rsp_data),
        .mem_addr(s_mem_addr), .mem_data(mem_data), .cpu_stall_cycles(s_stall)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_wait     = 0;
        m_stall    = 0;
        m_stall4   = 0;
        m_rsp_side = 0;
        m_rsp_addr = '0;
        m_last     = '0;
        g_vid      = 1'b0;
        g_cpu      = 1'b0;
    endtask

    // One cycle: drive, compare everything against the model, then apply the coming edge to the model.
    task automatic step(input logic vv, input logic [AW-1:0] va, input logic cv, input logic [AW-1:0] ca);
        logic          force_cpu;
        logic [AW-1:0] exp_addr;
        @(negedge clk);
        vid_req_valid = vv;
        vid_req_addr  = va;
        cpu_req_valid = cv;
        cpu_req_addr  = ca;
        #2;
        force_cpu = cv && (m_wait >= LIMIT);
        g_vid     = vv && !force_cpu;
        g_cpu     = cv && !g_vid;
        exp_addr  = g_vid ? va : (g_cpu ? ca : m_last);

        chk("vid_ready", 32'(vid_req_ready), 32'(g_vid));
        chk("cpu_ready", 32'(cpu_req_ready), 32'(g_cpu));
        chk("mem_addr", 32'(mem_addr), 32'(exp_addr));
        chk("vid_rsp_valid", 32'(vid_rsp_valid), 32'(m_rsp_side == 1));
        chk("cpu_rsp_valid", 32'(cpu_rsp_valid), 32'(m_rsp_side == 2));
        if (m_rsp_side == 1) chk("vid_rsp_data", 32'(vid_rsp_data), 32'(mem[m_rsp_addr]));
        if (m_rsp_side == 2) chk("cpu_rsp_data", 32'(cpu_rsp_data), 32'(mem[m_rsp_addr]));
        chk("stall16", 32'(cpu_stall_cycles), 32'(m_stall));
        chk("stall4", 32'(s_stall), 32'(m_stall4));

        if (g_vid || g_cpu) begin
            m_rsp_side = g_vid ? 1 : 2;
            m_rsp_addr = exp_addr;
            m_last     = exp_addr;
        end else begin
            m_rsp_side = 0;
        end
        if (cv && !g_cpu) begin
            m_stall  = (m_stall  < 65535) ? m_stall + 1  : 65535;
            m_stall4 = (m_stall4 < 15)    ? m_stall4 + 1 : 15;
        end
        if (!cv || g_cpu)  m_wait = 0;
        else if (g_vid)    m_wait = (m_wait < LIMIT) ? m_wait + 1 : LIMIT;
    endtask

    task automatic contention(input logic [AW-1:0] cpu_a, input logic pin);
        for (int c = 0; c < 10; c++) begin
            step(1'b1, AW'(c), c <= 8, cpu_a);
            if (pin) begin
                chk("cont_cpu_gnt", 32'(cpu_req_ready), 32'(c == 8));
                chk("cont_vid_gnt", 32'(vid_req_ready), 32'(c != 8));
            end
        end
    endtask

    initial begin
        logic          vp, cp;
        logic [AW-1:0] vaddr, caddr;
        for (int i = 0; i < (1 << AW); i++) mem[i] = 8'($urandom);
        mem[13'h0123] = 8'h5A;
        model_reset();

        // reset state
        #12;
        chk("rst_vid_rsp", 32'(vid_rsp_valid), 32'd0);
        chk("rst_cpu_rsp", 32'(cpu_rsp_valid), 32'd0);
        chk("rst_stall", 32'(cpu_stall_cycles), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // single CPU read
        step(1'b0, '0, 1'b1, 13'h0123);
        chk("cpu1_ready", 32'(cpu_req_ready), 32'd1);
        step(1'b0, '0, 1'b0, '0);
        chk("cpu1_rsp_valid", 32'(cpu_rsp_valid), 32'd1);
        chk("cpu1_rsp_data", 32'(cpu_rsp_data), 32'h5A);
        chk("cpu1_vid_rsp", 32'(vid_rsp_valid), 32'd0);

        // contention: CPU gets its slot after exactly LIMIT scanout grants
        contention(13'h0200, 1'b1);
        chk("cont_stall", 32'(cpu_stall_cycles), 32'd8);

        // alternating sides
        step(1'b1, 13'h0000, 1'b0, '0);
        step(1'b0, '0, 1'b1, 13'h1000);
        chk("alt_vid_rsp", 32'(vid_rsp_valid), 32'd1);
        step(1'b1, 13'h0001, 1'b0, '0);
        chk("alt_cpu_rsp", 32'(cpu_rsp_valid), 32'd1);
        chk("alt_cpu_data", 32'(cpu_rsp_data), 32'(mem[13'h1000]));
        step(1'b0, '0, 1'b0, '0);
        chk("alt_vid_rsp2", 32'(vid_rsp_valid), 32'd1);

        // idle hold
        step(1'b0, '0, 1'b1, 13'h0ABC);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, '0, 1'b0, '0);
            chk("idle_addr", 32'(mem_addr), 32'h0ABC);
            chk("idle_vid_rsp", 32'(vid_rsp_valid), 32'd0);
            if (i > 0) chk("idle_cpu_rsp", 32'(cpu_rsp_valid), 32'd0);
        end

        // random traffic with requesters holding until granted
        vp = 1'b0; cp = 1'b0; vaddr = '0; caddr = '0;
        for (int i = 0; i < 600; i++) begin
            if (!vp && $urandom_range(0, 99) < 75) begin vp = 1'b1; vaddr = AW'($urandom); end
            if (!cp && $urandom_range(0, 99) < 40) begin cp = 1'b1; caddr = AW'($urandom); end
            step(vp, vaddr, cp, caddr);
            if (g_vid) vp = 1'b0;
            if (g_cpu) cp = 1'b0;
        end

        // reset between a CPU grant and its response
        step(1'b0, '0, 1'b1, 13'h0321);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        vid_req_valid = 1'b0;
        cpu_req_valid = 1'b0;
        #1;
        chk("rstmid_cpu_rsp", 32'(cpu_rsp_valid), 32'd0);
        chk("rstmid_stall", 32'(cpu_stall_cycles), 32'd0);
        model_reset();
        @(negedge clk);
        #1;
        chk("rstmid_cpu_rsp2", 32'(cpu_rsp_valid), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        step(1'b0, '0, 1'b0, '0);
        chk("rstmid_addr", 32'(mem_addr), 32'd0);

        // starve count restarts from zero after reset; then saturate the narrow counter
        contention(13'h0400, 1'b1);
        contention(13'h0401, 1'b0);
        contention(13'h0402, 1'b0);
        chk("sat_stall16", 32'(cpu_stall_cycles), 32'd24);
        chk("sat_stall4", 32'(s_stall), 32'hF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
